// File: rtl/demux_pkg.sv
// Shared constants and slot-state encoding for the demux_reg fan-out block.
package demux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_N_OUTS = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_if.sv
// Stream bundle for demux_reg: one valid/ready input fanned out to N_OUTS valid/ready outputs.
interface demux_if
  import demux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_OUTS = DEF_N_OUTS
);
  localparam int SEL_WIDTH = $clog2(N_OUTS);

  // A transfer happens on any edge where valid and ready are both high; ready never looks at valid.
  logic                             in_valid;
  logic                             in_ready;
  logic [SEL_WIDTH-1:0]             in_sel;
  logic [WIDTH-1:0]                 in_data;
  logic [N_OUTS-1:0]                out_valid;
  logic [N_OUTS-1:0]                out_ready;
  logic [N_OUTS-1:0][WIDTH-1:0]     out_data;
  logic                             sel_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry output register: EMPTY/FULL state flop plus payload register.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic             drain,
  input  logic [WIDTH-1:0] fill_data,
  output slot_state_e      state,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A fill wins over a drain on the same edge so the slot never drops out of FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (fill) begin
      state_d = SLOT_FULL;
      data_d  = fill_data;
    end else if (state_q == SLOT_FULL && drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  assign state = state_q;
  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-N_OUTS stream demultiplexer with per-output one-entry slots.
// Optional DEMUX_PASSTHRU_EN lets a FULL slot accept new data in the cycle it drains.
module demux_reg
  import demux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_OUTS = DEF_N_OUTS
) (
  input  logic     clk,
  input  logic     rst,
  demux_if.slave   bus
);

  localparam int SEL_WIDTH = $clog2(N_OUTS);

  logic                         sel_ok;
  logic                         rdy_sel;
  logic                         accept;
  logic [N_OUTS-1:0]            fill;
  logic [N_OUTS-1:0]            slot_valid;
  logic [N_OUTS-1:0]            slot_rdy;
  logic [N_OUTS-1:0][WIDTH-1:0] slot_data;
  slot_state_e                  slot_state [N_OUTS];
  logic                         sel_err_q, sel_err_d;

  assign sel_ok = (32'(bus.in_sel) < 32'(N_OUTS));

`ifdef DEMUX_PASSTHRU_EN
  assign slot_rdy = ~slot_valid | bus.out_ready;
`else
  assign slot_rdy = ~slot_valid;
`endif

  // Loop-based select keeps an out-of-range index from reading past the slot array.
  always_comb begin
    rdy_sel = 1'b0;
    for (int k = 0; k < N_OUTS; k++) begin
      if (bus.in_sel == SEL_WIDTH'(k)) rdy_sel = slot_rdy[k];
    end
  end

  assign bus.in_ready = sel_ok & rdy_sel;
  assign accept       = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < N_OUTS; k++) begin : g_slot
    assign fill[k] = accept & (bus.in_sel == SEL_WIDTH'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[k]),
      .drain     (bus.out_ready[k]),
      .fill_data (bus.in_data),
      .state     (slot_state[k]),
      .valid     (slot_valid[k]),
      .data      (slot_data[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  always_comb begin
    sel_err_d = sel_err_q | (bus.in_valid & ~sel_ok);
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: a 4-output instance for data paths and a 3-output one for index errors.
module tb_demux_reg;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  demux_if #(.WIDTH(32), .N_OUTS(4)) i4 ();
  demux_if #(.WIDTH(32), .N_OUTS(3)) i3 ();

  demux_reg #(.WIDTH(32), .N_OUTS(4)) dut4 (.clk(clk), .rst(rst), .bus(i4.slave));
  demux_reg #(.WIDTH(32), .N_OUTS(3)) dut3 (.clk(clk), .rst(rst), .bus(i3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [1:0] sel, input logic [31:0] d,
                        input logic [3:0] ordy);
    i4.in_valid  = v;
    i4.in_sel    = sel;
    i4.in_data   = d;
    i4.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive4(1'b0, 2'd2, 32'h0, 4'b0000);
    i3.in_valid = 1'b0; i3.in_sel = 2'd0; i3.in_data = 32'h0; i3.out_ready = 3'b000;
    step();
    total++;
    if (i4.out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0000", i4.out_valid);
    end
    total++;
    if (i4.out_data !== 128'h0) begin
      bad++; $display("FAIL reset_out_data: got %h want 0", i4.out_data);
    end
    total++;
    if (i4.sel_err !== 1'b0 || i3.sel_err !== 1'b0) begin
      bad++; $display("FAIL reset_sel_err: got %b/%b want 0/0", i4.sel_err, i3.sel_err);
    end
    total++;
    if (i4.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", i4.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    drive4(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    step();
    total++;
    if (i4.out_valid !== 4'b0100) begin
      bad++; $display("FAIL fill_valid: got %b want 0100", i4.out_valid);
    end
    total++;
    if (i4.out_data[2] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL fill_data: got %h want deadbeef", i4.out_data[2]);
    end
    total++;
    if (i4.in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full_ready: got %b want 0", i4.in_ready);
    end
    i4.in_valid = 1'b0;
  endtask

  task automatic test_same_slot();
    drive4(1'b1, 2'd2, 32'h11, 4'b0100);
    #1;
`ifdef DEMUX_PASSTHRU_EN
    total++;
    if (i4.in_ready !== 1'b1) begin
      bad++; $display("FAIL pass_ready: got %b want 1", i4.in_ready);
    end
    step();
    total++;
    if (i4.out_valid !== 4'b0100 || i4.out_data[2] !== 32'h11) begin
      bad++; $display("FAIL pass_refill: got %b/%h want 0100/11", i4.out_valid, i4.out_data[2]);
    end
`else
    total++;
    if (i4.in_ready !== 1'b0) begin
      bad++; $display("FAIL half_ready: got %b want 0", i4.in_ready);
    end
    step();
    total++;
    if (i4.out_valid !== 4'b0000 || i4.in_ready !== 1'b1) begin
      bad++; $display("FAIL half_drain: got %b/%b want 0000/1", i4.out_valid, i4.in_ready);
    end
    step();
    total++;
    if (i4.out_valid !== 4'b0100 || i4.out_data[2] !== 32'h11) begin
      bad++; $display("FAIL half_refill: got %b/%h want 0100/11", i4.out_valid, i4.out_data[2]);
    end
`endif
    i4.in_valid = 1'b0;
    step();
    total++;
    if (i4.out_valid !== 4'b0000) begin
      bad++; $display("FAIL same_slot_empty: got %b want 0000", i4.out_valid);
    end
  endtask

  task automatic test_independent();
    drive4(1'b1, 2'd1, 32'h22, 4'b0000);
    step();
    drive4(1'b1, 2'd3, 32'h33, 4'b0000);
    #1;
    total++;
    if (i4.in_ready !== 1'b1) begin
      bad++; $display("FAIL indep_ready: got %b want 1", i4.in_ready);
    end
    step();
    i4.in_valid = 1'b0;
    total++;
    if (i4.out_valid !== 4'b1010) begin
      bad++; $display("FAIL indep_valid: got %b want 1010", i4.out_valid);
    end
    total++;
    if (i4.out_data[1] !== 32'h22 || i4.out_data[3] !== 32'h33) begin
      bad++; $display("FAIL indep_data: got %h/%h want 22/33", i4.out_data[1], i4.out_data[3]);
    end
  endtask

  task automatic test_all_drain();
    logic [3:0] exp_v;
    drive4(1'b1, 2'd0, 32'hA0, 4'b0000);
    step();
    drive4(1'b1, 2'd2, 32'hA2, 4'b0000);
    step();
    total++;
    if (i4.out_valid !== 4'b1111) begin
      bad++; $display("FAIL all_full: got %b want 1111", i4.out_valid);
    end
    drive4(1'b1, 2'd0, 32'h55, 4'b1111);
    step();
    drive4(1'b0, 2'd0, 32'h0, 4'b0000);
`ifdef DEMUX_PASSTHRU_EN
    exp_v = 4'b0001;
    total++;
    if (i4.out_data[0] !== 32'h55) begin
      bad++; $display("FAIL all_drain_data: got %h want 55", i4.out_data[0]);
    end
`else
    exp_v = 4'b0000;
`endif
    total++;
    if (i4.out_valid !== exp_v) begin
      bad++; $display("FAIL all_drain_valid: got %b want %b", i4.out_valid, exp_v);
    end
    i4.out_ready = 4'b1111;
    step();
    i4.out_ready = 4'b0000;
  endtask

  task automatic test_sel_err();
    i3.in_valid = 1'b1; i3.in_sel = 2'd3; i3.in_data = 32'hBAD; i3.out_ready = 3'b000;
    #1;
    total++;
    if (i3.in_ready !== 1'b0 || i3.sel_err !== 1'b0) begin
      bad++; $display("FAIL sel_err_pre: got rdy=%b err=%b want 0/0", i3.in_ready, i3.sel_err);
    end
    step();
    i3.in_valid = 1'b0;
    total++;
    if (i3.sel_err !== 1'b1 || i3.out_valid !== 3'b000) begin
      bad++; $display("FAIL sel_err_set: got err=%b v=%b want 1/000", i3.sel_err, i3.out_valid);
    end
    for (int i = 0; i < 3; i++) step();
    total++;
    if (i3.sel_err !== 1'b1) begin
      bad++; $display("FAIL sel_err_hold: got %b want 1", i3.sel_err);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      drive4(1'b1, 2'(k), 32'h100 + 32'(k), 4'b0000);
      step();
    end
    i4.in_valid = 1'b0;
    total++;
    if (i4.out_valid !== 4'b1111) begin
      bad++; $display("FAIL arst_prefill: got %b want 1111", i4.out_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (i4.out_valid !== 4'b0000 || i3.sel_err !== 1'b0) begin
      bad++; $display("FAIL arst_immediate: got v=%b err=%b want 0000/0", i4.out_valid, i3.sel_err);
    end
    step();
    rst = 1'b0;
    drive4(1'b1, 2'd1, 32'h77, 4'b0000);
    step();
    i4.in_valid = 1'b0;
    total++;
    if (i4.out_valid !== 4'b0010 || i4.out_data[1] !== 32'h77) begin
      bad++; $display("FAIL arst_refill: got %b/%h want 0010/77", i4.out_valid, i4.out_data[1]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_same_slot();
    test_independent();
    test_all_drain();
    test_sel_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
# demux_reg

Registered N-way demultiplexer that steers a single valid/ready input stream to one of `N_OUTS` output streams, chosen per transfer by an index. It is the fan-out counterpart to the N-to-1 select mux. It sits wherever one producer feeds several consumers, such as dispatch to issue queues or a writeback-to-unit fan-out. Each output holds a one-entry register, so a stalled consumer blocks only transfers steered to it.

## Interface
- `WIDTH`, 32, payload bits per transfer
- `N_OUTS`, 4, number of output ports; must be ≥ 2
- `SEL_WIDTH`, `$clog2(N_OUTS)` (localparam), index width
- Reset is asynchronous and active-high; one clock.
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: input transfer offered
- `in_ready` out 1: input accepted this cycle when high with `in_valid`
- `in_sel` in `SEL_WIDTH`: destination index, sampled with `in_valid`
- `in_data` in `WIDTH`: payload
- `out_valid` out `N_OUTS`: per-output slot occupied
- `out_ready` in `N_OUTS`: per-output consumer accept
- `out_data` out `[N_OUTS][WIDTH]`: per-output payload register
- `sel_err` out 1: sticky flag, set when `in_valid` is high with `in_sel ≥ N_OUTS`

## Operation
- Per-output slot state: EMPTY (`out_valid[k]=0`) or FULL (`out_valid[k]=1`).
- Input transfer: `in_valid & in_ready`.
  - Writes `in_data` into slot `in_sel`.
  - Sets that slot FULL on the next edge.
- Output transfer on port k: `out_valid[k] & out_ready[k]`.
  - Clears slot k on the next edge, unless the same edge refills it.
- `in_ready` is purely combinational from `in_sel`, slot state, and (with `DEMUX_PASSTHRU_EN`) `out_ready[in_sel]`.
  - It never depends on `in_valid`.
  - It is 0 whenever `in_sel ≥ N_OUTS`. Such an input is never accepted.
- Out-of-range index:
  - `sel_err` sets on the next edge when `in_valid` is high with `in_sel ≥ N_OUTS`.
  - It stays set until `rst`.
  - No slot changes.
- Payload is held stable in a FULL slot until it is drained. `out_data[k]` is don't-care while `out_valid[k]=0`.
- Slots are independent. Any number of outputs may drain in the same cycle as one input fill.
- Ordering is preserved per output, trivially, since each slot holds one entry. No ordering is guaranteed across outputs.

## Timing
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - `sel_err` = 0
  - `in_ready` follows from the empty slots, so it is 1 for any in-range `in_sel`.
- Latency: data accepted at edge t appears on `out_valid`/`out_data` after edge t, i.e. one cycle.
- Throughput per output:
  - 1 transfer every 2 cycles without `DEMUX_PASSTHRU_EN`.
  - 1 per cycle with it.
- Simultaneous fill and drain of the same FULL slot (passthru only): the slot stays FULL and takes the new data. `out_valid[k]` does not glitch low.
- Fill of slot k while another slot j drains: both take effect; no interaction.
- `rst` asserted mid-operation:
  - All slots empty immediately (asynchronous), and in-flight data is dropped.
  - `sel_err` clears.
  - The first transfer is accepted at the first edge after `rst` deasserts.

## Configuration
- `DEMUX_PASSTHRU_EN` defined:
  - `in_ready = (slot in_sel EMPTY) | out_ready[in_sel]`, with `in_sel` in range.
  - This gives full-rate streaming through a slot.
  - It adds a combinational path from `out_ready` to `in_ready`.
- Undefined:
  - `in_ready = slot in_sel EMPTY` only.
  - No combinational `out_ready`→`in_ready` path.
  - Half-rate per output.

## Structure
- Package `demux_pkg`: holds the default `WIDTH`/`N_OUTS` constants and the slot-state encoding constants (EMPTY=0, FULL=1).
- Sub-module `demux_slot`: one per output, instantiated in a generate loop.
  - Holds the valid flop and the data register.
  - Inputs: fill enable (the decoded `in_sel` one-hot ANDed with the transfer) and drain (`out_ready`).
  - Outputs: `valid` and `data`.
- The top level contains the index decode, the range check, the `in_ready` select (an `N_OUTS`:1 select of per-slot ready), and the `sel_err` flop.

## Test plan
- Reset, then `in_valid=1`, `in_sel=2`, `in_data=0xDEADBEEF`, `out_ready=0` → after one edge `out_valid=4'b0100`, `out_data[2]=0xDEADBEEF`; next cycle with `in_sel=2`, `in_ready=0`.
- Slot 2 FULL, `out_ready[2]=1`, new input 0x11 to `in_sel=2`:
  - Passthru → accepted, `out_data[2]=0x11`, and `out_valid[2]` stays 1.
  - Non-passthru → `in_ready=0`; the slot empties, and 0x11 is accepted the following cycle.
- Slot 1 FULL and stalled, input to `in_sel=3` with value 0x33 → accepted; `out_valid=4'b1010`, with slot 1 data unchanged.
- `N_OUTS=3`, `in_valid=1`, `in_sel=3` → `in_ready=0`, no slot changes, `sel_err=1` after the edge and held until `rst`.
- All four slots FULL with `out_ready=4'b1111` and an input to slot 0 (passthru) → after the edge `out_valid=4'b0001`.
- `rst` pulsed mid-cycle with all slots FULL → `out_valid=0` immediately, before the next edge; a fill after release appears one cycle later.
